// File: rtl/microwave_pkg.sv
// Shared encodings and limits for the microwave cook timer: FSM states,
// BCD digit limits and the quick-start defaults.
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COOK  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DONE  = 3'd3
    } state_e;

    localparam logic [3:0] DIGIT_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX   = 4'd5;
    localparam logic [3:0] QUICK_MIN_DEF  = 4'd0;
    localparam logic [3:0] QUICK_TENS_DEF = 4'd3;

    function automatic logic is_bcd(input logic [3:0] value);
        return value <= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit. Priority is load, then shift-in, then decrement;
// decrementing from 0 wraps to MAX and raises borrow for the next digit up.
module bcd_down_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       shift_en,
    input  logic [3:0] shift_in,
    input  logic       dec,
    output logic [3:0] digit,
    output logic       borrow
);

    logic [3:0] digit_d;
    logic [3:0] digit_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (shift_en) begin
            digit_d = shift_in;
        end else if (dec) begin
            digit_d = (digit_q == 4'd0) ? MAX : digit_q - 4'd1;
        end
    end

    // NOTE: state flops use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clock) begin
        if (clear) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit  = digit_q;
    assign borrow = (digit_q == 4'd0) && dec;

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook timer: keypad entry of M:SS, start/stop/door sequencing and a
// 1 Hz countdown through a chain of three BCD down-counting digits.
module microwave_timer_ctrl
    import microwave_pkg::*;
#(
    parameter logic [3:0] QUICK_MIN  = QUICK_MIN_DEF,
    parameter logic [3:0] QUICK_TENS = QUICK_TENS_DEF
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       door_closed,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic       tick,
    output logic [3:0] min_digit,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       magnetron_on,
    output logic       done,
    output logic [2:0] state_o
);

    state_e state_d;
    state_e state_q;

    logic       load;
    logic [3:0] load_min;
    logic [3:0] load_tens;
    logic       shift_en;
    logic       cook_dec;
    logic       borrow_units;
    logic       borrow_tens;
    logic       borrow_min;
    logic       time_zero;
    logic       time_one;
    logic       key_ok;

    assign time_zero = (min_digit == 4'd0) && (sec_tens == 4'd0) && (sec_units == 4'd0);
    assign time_one  = (min_digit == 4'd0) && (sec_tens == 4'd0) && (sec_units == 4'd1);
    // The old units digit moves into seconds-tens, so it must not exceed 5.
    assign key_ok    = is_bcd(key) && (sec_units <= SEC_TENS_MAX);

    // Kept independent of the FSM block so the borrow chain never loops back into it.
    assign cook_dec  = (state_q == ST_COOK) && tick && door_closed && !stop_clear;

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        load_min  = 4'd0;
        load_tens = 4'd0;
        shift_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (stop_clear) begin
                    load = 1'b1;
                end else if (start) begin
                    if (door_closed) begin
                        state_d = ST_COOK;
                        if (time_zero) begin
                            load      = 1'b1;
                            load_min  = QUICK_MIN;
                            load_tens = QUICK_TENS;
                        end
                    end
                end else if (key_valid && key_ok) begin
                    shift_en = 1'b1;
                end
            end
            ST_COOK: begin
                if (stop_clear || !door_closed) begin
                    state_d = ST_PAUSE;
                end else if (tick && (time_one || borrow_min)) begin
                    // A minutes borrow would be an underflow; finish rather than wrap.
                    state_d = ST_DONE;
                    load    = borrow_min;
                end
            end
            ST_PAUSE: begin
                if (stop_clear) begin
                    state_d = ST_IDLE;
                    load    = 1'b1;
                end else if (start && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (stop_clear || !door_closed) begin
                    state_d = ST_IDLE;
                    load    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                load    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    bcd_down_digit #(.MAX(DIGIT_MAX)) u_units (
        .clock    (clock),
        .clear    (clear),
        .load     (load),
        .load_val (4'd0),
        .shift_en (shift_en),
        .shift_in (key),
        .dec      (cook_dec),
        .digit    (sec_units),
        .borrow   (borrow_units)
    );

    bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_tens (
        .clock    (clock),
        .clear    (clear),
        .load     (load),
        .load_val (load_tens),
        .shift_en (shift_en),
        .shift_in (sec_units),
        .dec      (borrow_units),
        .digit    (sec_tens),
        .borrow   (borrow_tens)
    );

    bcd_down_digit #(.MAX(DIGIT_MAX)) u_min (
        .clock    (clock),
        .clear    (clear),
        .load     (load),
        .load_val (load_min),
        .shift_en (shift_en),
        .shift_in (sec_tens),
        .dec      (borrow_tens),
        .digit    (min_digit),
        .borrow   (borrow_min)
    );

    assign magnetron_on = (state_q == ST_COOK);
    assign done         = (state_q == ST_DONE);
    assign state_o      = state_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed, table-driven bench for microwave_timer_ctrl: one vector per clock,
// with hand-computed digits, state and flags expected after each edge.
module tb_microwave_timer_ctrl;

    logic       clock = 1'b0;
    logic       clear;
    logic       door_closed;
    logic       start;
    logic       stop_clear;
    logic       key_valid;
    logic [3:0] key;
    logic       tick;
    logic [3:0] min_digit;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic       magnetron_on;
    logic       done;
    logic [2:0] state_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic       clr;
        logic       door;
        logic       st;
        logic       sp;
        logic       kv;
        logic [3:0] k;
        logic       tk;
        logic [3:0] em;
        logic [3:0] et;
        logic [3:0] eu;
        logic [2:0] est;
        logic       emag;
        logic       edone;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    microwave_timer_ctrl dut (
        .clock        (clock),
        .clear        (clear),
        .door_closed  (door_closed),
        .start        (start),
        .stop_clear   (stop_clear),
        .key_valid    (key_valid),
        .key          (key),
        .tick         (tick),
        .min_digit    (min_digit),
        .sec_tens     (sec_tens),
        .sec_units    (sec_units),
        .magnetron_on (magnetron_on),
        .done         (done),
        .state_o      (state_o)
    );

    function automatic vec_t mk(input logic clr, input logic door, input logic st,
                                input logic sp, input logic kv, input logic [3:0] k,
                                input logic tk, input logic [3:0] em, input logic [3:0] et,
                                input logic [3:0] eu, input logic [2:0] est);
        vec_t v;
        v.clr = clr; v.door = door; v.st = st; v.sp = sp; v.kv = kv; v.k = k; v.tk = tk;
        v.em = em; v.et = et; v.eu = eu; v.est = est;
        v.emag  = (est == 3'd1);
        v.edone = (est == 3'd3);
        return v;
    endfunction

    task automatic check(input string name, input logic [16:0] actual, input logic [16:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got {m,t,u,st,mag,done}=%05h expected %05h", name, actual, expected);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        clear       = v.clr;
        door_closed = v.door;
        start       = v.st;
        stop_clear  = v.sp;
        key_valid   = v.kv;
        key         = v.k;
        tick        = v.tk;
        @(posedge clock);
        #1;
        check(name, {min_digit, sec_tens, sec_units, state_o, magnetron_on, done},
              {v.em, v.et, v.eu, v.est, v.emag, v.edone});
    endtask

    initial begin
        clear = 1'b0; door_closed = 1'b1; start = 1'b0; stop_clear = 1'b0;
        key_valid = 1'b0; key = 4'd0; tick = 1'b0;

        //                clr door st sp kv key tk   m  t  u  st
        vecs.push_back(mk(1, 1, 0, 0, 0, 4'd0, 0,  0, 0, 0, 0));  // reset
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'd1, 0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'd2, 0,  0, 1, 2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'd3, 0,  1, 2, 3, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0,  1, 2, 3, 1));  // start 1:23
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 1,  1, 2, 2, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 1,  1, 2, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 1,  1, 2, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0,  1, 2, 0, 1));  // no tick, hold
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'd0, 0,  1, 2, 0, 2));  // stop -> PAUSE
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'd0, 0,  0, 0, 0, 0));  // stop -> IDLE
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'd1, 0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'd0, 0,  0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'd0, 0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0,  1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 1,  0, 5, 9, 1));  // 1:00 -> 0:59
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'd0, 0,  0, 5, 9, 2));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'd0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'd1, 0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0,  0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 1,  0, 0, 0, 3));  // 0:01 -> DONE
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 1,  0, 0, 0, 3));  // tick ignored
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0,  0, 0, 0, 3));  // start ignored
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'd5, 0,  0, 0, 0, 3));  // key ignored
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'd0, 0,  0, 0, 0, 0));  // stop -> IDLE
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0,  0, 3, 0, 1));  // quick start 0:30
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'd0, 0,  0, 3, 0, 2));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'd0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'd0, 0,  0, 0, 0, 0));  // start, door open
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'd7, 0,  0, 0, 7, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'd2, 0,  0, 0, 7, 0));  // units 7 > 5: reject
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'hA, 0,  0, 0, 7, 0));  // non-BCD key
        vecs.push_back(mk(0, 1, 0, 1, 1, 4'd3, 0,  0, 0, 0, 0));  // stop beats key
        vecs.push_back(mk(0, 1, 1, 0, 1, 4'd5, 0,  0, 3, 0, 1));  // start beats key
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'd0, 0,  0, 3, 0, 2));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'd0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'd1, 0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0,  0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 1,  0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 0,  0, 0, 0, 0));  // door opens in DONE

        @(negedge clock);
        foreach (vecs[i]) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Door opens in the same cycle as a tick at 0:45.
        step(mk(0, 1, 0, 0, 1, 4'd4, 0,  0, 0, 4, 0), "pause_key4");
        step(mk(0, 1, 0, 0, 1, 4'd5, 0,  0, 4, 5, 0), "pause_key5");
        step(mk(0, 1, 1, 0, 0, 4'd0, 0,  0, 4, 5, 1), "pause_start");
        step(mk(0, 0, 0, 0, 0, 4'd0, 1,  0, 4, 5, 2), "pause_door_tick");
        step(mk(0, 0, 0, 0, 0, 4'd0, 1,  0, 4, 5, 2), "pause_tick_held");
        step(mk(0, 1, 0, 0, 1, 4'd1, 0,  0, 4, 5, 2), "pause_key_ignored");
        step(mk(0, 0, 1, 0, 0, 4'd0, 0,  0, 4, 5, 2), "pause_start_door_open");
        step(mk(0, 1, 1, 0, 0, 4'd0, 0,  0, 4, 5, 1), "pause_resume");
        step(mk(0, 1, 0, 0, 0, 4'd0, 1,  0, 4, 4, 1), "pause_resume_tick");

        // Synchronous clear mid-COOK, then start and stop together in PAUSE.
        step(mk(0, 1, 0, 1, 0, 4'd0, 0,  0, 4, 4, 2), "clr_stop1");
        step(mk(0, 1, 0, 1, 0, 4'd0, 0,  0, 0, 0, 0), "clr_stop2");
        step(mk(0, 1, 0, 0, 1, 4'd2, 0,  0, 0, 2, 0), "clr_key2");
        step(mk(0, 1, 0, 0, 1, 4'd1, 0,  0, 2, 1, 0), "clr_key1");
        step(mk(0, 1, 0, 0, 1, 4'd0, 0,  2, 1, 0, 0), "clr_key0");
        step(mk(0, 1, 1, 0, 0, 4'd0, 0,  2, 1, 0, 1), "clr_start");
        step(mk(0, 1, 0, 0, 0, 4'd0, 1,  2, 0, 9, 1), "clr_tick_2_09");
        step(mk(1, 1, 1, 0, 0, 4'd0, 1,  0, 0, 0, 0), "clr_mid_cook");
        step(mk(0, 1, 0, 0, 1, 4'd5, 0,  0, 0, 5, 0), "pair_key5");
        step(mk(0, 1, 1, 0, 0, 4'd0, 0,  0, 0, 5, 1), "pair_start");
        step(mk(0, 1, 0, 1, 0, 4'd0, 0,  0, 0, 5, 2), "pair_pause");
        step(mk(0, 1, 1, 1, 0, 4'd0, 0,  0, 0, 0, 0), "pair_start_stop");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
